// File: rtl/alu_result_stage.sv
// Registered 2-entry skid stage for CLA adder results and flags, plus sticky carry/overflow and a delivered-result count.
// Optional head-entry parity check enabled by ALU_RESULT_PARITY_CHECK_EN.
module alu_result_stage #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_z,
    input  logic               in_zero,
    input  logic               in_sign,
    input  logic               in_carry,
    input  logic               in_parity,
    input  logic               in_overflow,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_z,
    output logic [4:0]         out_flags,
    input  logic               sticky_clr,
    output logic               sticky_carry,
    output logic               sticky_overflow,
    output logic [COUNT_W-1:0] res_count
`ifdef ALU_RESULT_PARITY_CHECK_EN
    ,
    output logic               parity_err
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             pop;
    logic             load_head;
    logic             load_tail;
    logic             promote;
    logic [4:0]       in_flags;
    logic [WIDTH-1:0] tail_z;
    logic [4:0]       tail_flags;

    assign in_flags  = {in_overflow, in_parity, in_carry, in_sign, in_zero};
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Head is written directly on accept whenever it is (or is about to be) free.
    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        load_tail = 1'b0;
        promote   = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    promote   = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_z      <= '0;
            out_flags  <= '0;
            tail_z     <= '0;
            tail_flags <= '0;
        end else begin
            if (load_head) begin
                out_z     <= in_z;
                out_flags <= in_flags;
            end else if (promote) begin
                out_z     <= tail_z;
                out_flags <= tail_flags;
            end
            if (load_tail) begin
                tail_z     <= in_z;
                tail_flags <= in_flags;
            end
        end
    end

    // A same-cycle accept with the flag set overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_carry    <= 1'b0;
            sticky_overflow <= 1'b0;
            res_count       <= '0;
        end else begin
            sticky_carry    <= (sticky_carry    & ~sticky_clr) | (accept & in_carry);
            sticky_overflow <= (sticky_overflow & ~sticky_clr) | (accept & in_overflow);
            if (pop) begin
                res_count <= res_count + COUNT_W'(1);
            end
        end
    end

`ifdef ALU_RESULT_PARITY_CHECK_EN
    assign parity_err = out_valid & (out_flags[3] != ~^out_z);
`endif

endmodule
